// File: rtl/cache_ctrl_nway.sv
// N-way set-associative, write-through, write-update data cache controller with tree pseudo-LRU.
// Optional hit/miss statistics outputs are enabled by defining CACHE_NWAY_STATS_EN.
module cache_ctrl_nway #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready,
    output logic [1:0]  dbg_state
`ifdef CACHE_NWAY_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int SETS   = 1 << INDEX_W;
    localparam int WAY_W  = (WAYS > 2) ? 2 : 1;
    localparam int PLRU_W = WAYS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state;

    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [SETS-1:0][PLRU_W-1:0] plru_q;
    logic [TAG_W-1:0]            tag_q  [SETS][WAYS];
    logic [63:0]                 data_q [SETS][WAYS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               word_sel;

    assign idx      = address[3+INDEX_W-1:3];
    assign tag      = address[3+INDEX_W+TAG_W-1:3+INDEX_W];
    assign word_sel = address[2];

    logic unused_bits;
    assign unused_bits = &{1'b0, address[1:0], address[31:3+INDEX_W+TAG_W]};

    assign sram_address = address;
    assign sram_wdata   = wdata;
    assign dbg_state    = state;

    logic             hit;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    logic [PLRU_W-1:0] plru_cur;
    logic [PLRU_W-1:0] plru_hit_nxt;
    logic [PLRU_W-1:0] plru_fill_nxt;
    logic [WAY_W-1:0]  plru_vict;
    logic [WAY_W-1:0]  victim;
    logic              found_invalid;

    assign plru_cur = plru_q[idx];

    // Tree bits point at the side to evict next; touching a way points them away from it.
    generate
        if (WAYS == 2) begin : g_plru2
            assign plru_vict     = plru_cur[0];
            assign plru_hit_nxt  = ~hit_way[0];
            assign plru_fill_nxt = ~victim[0];
        end else begin : g_plru4
            function automatic logic [2:0] touch(input logic [2:0] p, input logic [1:0] w);
                touch = w[1] ? {~w[0], p[1], 1'b0} : {p[2], ~w[0], 1'b1};
            endfunction
            assign plru_vict     = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
            assign plru_hit_nxt  = touch(plru_cur, hit_way);
            assign plru_fill_nxt = touch(plru_cur, victim);
        end
    endgenerate

    always_comb begin
        found_invalid = 1'b0;
        victim        = plru_vict;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_q[idx][w]) begin
                found_invalid = 1'b1;
                victim        = WAY_W'(w);
            end
        end
    end

    logic [63:0] line;

    always_comb begin
        line  = (state == FILL) ? sram_rdata : data_q[idx][hit_way];
        rdata = word_sel ? line[63:32] : line[31:0];
    end

    always_comb begin
        ready = 1'b1;
        case (state)
            IDLE: begin
                if (mem_w_en)      ready = 1'b0;
                else if (mem_r_en) ready = hit;
            end
            FILL, WRITE: ready = sram_ready;
            default: ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            valid_q    <= '0;
            plru_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        state      <= WRITE;
                        sram_write <= 1'b1;
                    end else if (mem_r_en) begin
                        if (hit) begin
                            plru_q[idx] <= plru_hit_nxt;
                        end else begin
                            state     <= FILL;
                            sram_read <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (sram_ready) begin
                        valid_q[idx][victim] <= 1'b1;
                        tag_q[idx][victim]   <= tag;
                        data_q[idx][victim]  <= sram_rdata;
                        plru_q[idx]          <= plru_fill_nxt;
                        sram_read            <= 1'b0;
                        state                <= IDLE;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        if (hit) begin
                            if (word_sel) data_q[idx][hit_way][63:32] <= wdata;
                            else          data_q[idx][hit_way][31:0]  <= wdata;
                        end
                        sram_write <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_NWAY_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && !mem_w_en && mem_r_en) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
